// File: rtl/zl_status_led_ctrl.sv
// Status LED controller: heartbeat, pulse-stretched activity LEDs and sticky
// error LEDs packed into one registered LED bus, with a lamp-test override.
module zl_status_led_ctrl #(
  parameter int Led_width        = 8,
  parameter int Num_act          = 2,
  parameter int Num_err          = 2,
  parameter int Heartbeat_period = 25000000,
  parameter int Stretch_cycles   = 2500000,
  parameter int Err_blink        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [Num_act-1:0]   act_in,
  input  logic [Num_err-1:0]   err_in,
  input  logic                 err_clear,
  input  logic                 lamp_test,
  output logic [Num_err-1:0]   err_flags,
  output logic [Led_width-1:0] led_out
);

  localparam int HB_W = $clog2(Heartbeat_period);
  localparam int ST_W = $clog2(Stretch_cycles + 1);

  if (1 + Num_act + Num_err > Led_width) begin : g_width_check
    $error("zl_status_led_ctrl: Led_width too small for 1+Num_act+Num_err LEDs");
  end

  logic [HB_W-1:0]      hb_cnt;
  logic                 hb_state;
  logic [ST_W-1:0]      stretch_cnt [Num_act];
  logic [Led_width-1:0] led_map;

  // LED map is built from the current register values; led_out registers it.
  always_comb begin
    led_map    = '0;
    led_map[0] = hb_state;
    for (int i = 0; i < Num_act; i++) begin
      led_map[1+i] = (stretch_cnt[i] != '0);
    end
    for (int j = 0; j < Num_err; j++) begin
      if (Err_blink != 0) begin
        led_map[1+Num_act+j] = err_flags[j] & hb_state;
      end else begin
        led_map[1+Num_act+j] = err_flags[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt    <= '0;
      hb_state  <= 1'b0;
      err_flags <= '0;
      led_out   <= '0;
      for (int i = 0; i < Num_act; i++) begin
        stretch_cnt[i] <= '0;
      end
    end else begin
      if (hb_cnt == HB_W'(Heartbeat_period - 1)) begin
        hb_cnt   <= '0;
        hb_state <= ~hb_state;
      end else begin
        hb_cnt <= hb_cnt + HB_W'(1);
      end

      // A strobe reloads the full on-time rather than adding to it.
      for (int i = 0; i < Num_act; i++) begin
        if (act_in[i]) begin
          stretch_cnt[i] <= ST_W'(Stretch_cycles);
        end else if (stretch_cnt[i] != '0) begin
          stretch_cnt[i] <= stretch_cnt[i] - ST_W'(1);
        end
      end

      err_flags <= err_in | (err_clear ? '0 : err_flags);
      led_out   <= lamp_test ? '1 : led_map;
    end
  end

endmodule

// File: tb/tb_zl_status_led_ctrl.sv
// Self-checking bench for zl_status_led_ctrl: an event-time model of the LED
// bus checked every cycle, plus literal expectations at key points.
module tb_zl_status_led_ctrl;

  localparam int HP = 4;
  localparam int SC = 3;

  logic       clk;
  logic       rst;
  logic [1:0] act_in;
  logic [1:0] err_in;
  logic       err_clear;
  logic       lamp_test;
  logic [1:0] err_flags;
  logic [7:0] led_out;

  int checks = 0;
  int errors = 0;

  zl_status_led_ctrl #(
    .Led_width(8), .Num_act(2), .Num_err(2),
    .Heartbeat_period(HP), .Stretch_cycles(SC), .Err_blink(1)
  ) dut (
    .clk(clk), .rst(rst), .act_in(act_in), .err_in(err_in),
    .err_clear(err_clear), .lamp_test(lamp_test),
    .err_flags(err_flags), .led_out(led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: heartbeat from edges since reset, activity from the edge of the
  // last strobe, flags from set/clear rules.
  int         edge_num = 0;
  int         hb_n = 0;
  int         last_act [2];
  bit         act_seen [2];
  logic [1:0] m_flags = '0;
  logic [7:0] m_map;
  logic [7:0] exp_led = '0;
  logic [1:0] exp_flags = '0;
  bit         model_valid = 0;

  always @(posedge clk) begin
    edge_num++;
    if (rst) begin
      hb_n     = 0;
      act_seen = '{0, 0};
      m_flags  = '0;
      exp_led  = '0;
    end else begin
      m_map    = '0;
      m_map[0] = ((hb_n / HP) % 2) == 1;
      for (int i = 0; i < 2; i++) begin
        m_map[1+i] = act_seen[i] && (edge_num - last_act[i] >= 1)
                     && (edge_num - last_act[i] <= SC);
      end
      for (int j = 0; j < 2; j++) begin
        m_map[3+j] = m_flags[j] & m_map[0];
      end
      exp_led = lamp_test ? 8'hFF : m_map;
      hb_n++;
      for (int i = 0; i < 2; i++) begin
        if (act_in[i]) begin
          act_seen[i] = 1;
          last_act[i] = edge_num;
        end
      end
      m_flags = err_in | (err_clear ? 2'b00 : m_flags);
    end
    exp_flags   = m_flags;
    model_valid = 1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (led_out !== exp_led) begin
        errors++;
        $display("[TB] FAIL model_led @%0t: got %h expected %h", $time, led_out, exp_led);
      end
      checks++;
      if (err_flags !== exp_flags) begin
        errors++;
        $display("[TB] FAIL model_flags @%0t: got %h expected %h", $time, err_flags, exp_flags);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic [1:0] act, input logic [1:0] err,
                               input logic clr, input logic lamp, input int cycles);
    rst       = r;
    act_in    = act;
    err_in    = err;
    err_clear = clr;
    lamp_test = lamp;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  initial begin
    rst = 1'b1; act_in = '0; err_in = '0; err_clear = 1'b0; lamp_test = 1'b0;
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 3);
    checkOutput("reset_led", led_out, 8'h00);
    checkOutput("reset_flags", {6'b0, err_flags}, 8'h00);

    // Heartbeat: low for 4 edges, high for 4, low again.
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 4);
    checkOutput("hb_low", led_out, 8'h00);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 1);
    checkOutput("hb_high", led_out, 8'h01);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 4);
    checkOutput("hb_low_again", led_out, 8'h00);

    // Single activity pulse on channel 0.
    applyStimulus(0, 2'b01, 2'b00, 0, 0, 1);
    checkOutput("stretch_not_yet", {7'b0, led_out[1]}, 8'h00);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 1);
    checkOutput("stretch_on_first", {7'b0, led_out[1]}, 8'h01);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 2);
    checkOutput("stretch_on_last", {7'b0, led_out[1]}, 8'h01);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 1);
    checkOutput("stretch_off", {7'b0, led_out[1]}, 8'h00);

    // Retrigger on channel 1, then a held strobe.
    applyStimulus(0, 2'b10, 2'b00, 0, 0, 1);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 1);
    applyStimulus(0, 2'b10, 2'b00, 0, 0, 1);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 6);
    applyStimulus(0, 2'b10, 2'b00, 0, 0, 10);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 5);

    // Sticky errors with blink, clear, and set-wins.
    applyStimulus(0, 2'b00, 2'b01, 0, 0, 1);
    checkOutput("err_set", {6'b0, err_flags}, 8'h01);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 9);
    checkOutput("err_held", {6'b0, err_flags}, 8'h01);
    applyStimulus(0, 2'b00, 2'b00, 1, 0, 1);
    checkOutput("err_cleared", {6'b0, err_flags}, 8'h00);
    applyStimulus(0, 2'b00, 2'b01, 0, 0, 1);
    applyStimulus(0, 2'b00, 2'b01, 1, 0, 1);
    checkOutput("err_set_wins", {6'b0, err_flags}, 8'h01);
    applyStimulus(0, 2'b00, 2'b10, 0, 0, 1);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 8);

    // Lamp test in the middle of a stretch.
    applyStimulus(0, 2'b01, 2'b00, 0, 0, 1);
    applyStimulus(0, 2'b00, 2'b00, 0, 1, 1);
    checkOutput("lamp_on", led_out, 8'hFF);
    applyStimulus(0, 2'b00, 2'b00, 0, 1, 4);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 1);
    checkOutput("lamp_release_stretch_done", {7'b0, led_out[1]}, 8'h00);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 3);

    // Reset with flags set and stretches active.
    applyStimulus(0, 2'b11, 2'b11, 0, 0, 1);
    applyStimulus(1, 2'b11, 2'b11, 0, 1, 1);
    checkOutput("midreset_led", led_out, 8'h00);
    checkOutput("midreset_flags", {6'b0, err_flags}, 8'h00);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 4);
    checkOutput("restart_hb_low", led_out, 8'h00);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 1);
    checkOutput("restart_hb_high", led_out, 8'h01);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
